// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bus master controller, arbiter and bus mux.
//   - bm_state_t : master FSM state encoding (IDLE=0, REQ=1, XFER=2, DONE=3)
//   - ADDR_W_DEF / DATA_W_DEF / LEN_W_DEF : default bus field widths
// -----------------------------------------------------------------------------
package bus_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;
   localparam int LEN_W_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } bm_state_t;

endpackage

// File: rtl/bus_master_ctrl_if.sv
// -----------------------------------------------------------------------------
// bus_master_ctrl_if
// Command handshake plus arbitrated bus signals of one bus master.
//   modport master : the controller (takes commands, drives the bus)
//   modport slave  : the command source / arbiter / memory side
// Signals: cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_len/cmd_wdata,
//          M_req/M_grant/M_addr/M_wr/M_dout/M_din, rd_valid/rd_data, done.
// -----------------------------------------------------------------------------
interface bus_master_ctrl_if
   import bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic [DATA_W-1:0] cmd_wdata;

   logic              M_req;
   logic              M_grant;
   logic [ADDR_W-1:0] M_addr;
   logic              M_wr;
   logic [DATA_W-1:0] M_dout;
   logic [DATA_W-1:0] M_din;

   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              done;

   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_wdata, M_grant, M_din,
      output cmd_ready, M_req, M_addr, M_wr, M_dout, rd_valid, rd_data, done
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_wdata, M_grant, M_din,
      input  cmd_ready, M_req, M_addr, M_wr, M_dout, rd_valid, rd_data, done
   );

endinterface

// File: rtl/bm_beat_cnt.sv
// -----------------------------------------------------------------------------
// bm_beat_cnt
// Beat index of the current burst.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : return index to 0 (command accept)
//   inc          : advance to next beat (held when neither clr nor inc)
//   len          : latched burst length minus 1
//   idx          : current beat index
//   last         : idx == len, i.e. the current beat is the final one
// -----------------------------------------------------------------------------
module bm_beat_cnt #(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             inc,
   input  logic [LEN_W-1:0] len,
   output logic [LEN_W-1:0] idx,
   output logic             last
);

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      if (!reset_n)
         idx <= '0;
      else if (clr)
         idx <= '0;
      else if (inc)
         idx <= idx + LEN_W'(1);
   end

   assign last = (idx == len);

endmodule

// File: rtl/bus_master_ctrl.sv
// -----------------------------------------------------------------------------
// bus_master_ctrl
// Accepts one burst command at a time, requests the bus, issues cmd_len+1
// beats (address base+i, write data seed+i) while granted, returns read data
// one cycle after each read beat, and pulses done when the burst completes.
// A lost grant mid-burst re-enters REQ and resumes from the same beat.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : bus_master_ctrl_if.master (command handshake + bus)
//   csum         : running sum of returned read data for the current burst,
//                  present only when BUS_MASTER_CSUM_EN is defined
// -----------------------------------------------------------------------------
module bus_master_ctrl
   import bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
`ifdef BUS_MASTER_CSUM_EN
   output logic [DATA_W-1:0] csum,
`endif
   bus_master_ctrl_if.master bus
);

   bm_state_t         state, state_nxt;
   logic              accept;
   logic              beat;
   logic              cnt_clr;
   logic              cnt_inc;
   logic              last;
   logic [LEN_W-1:0]  idx;

   logic              wr_q;
   logic [ADDR_W-1:0] base_q;
   logic [LEN_W-1:0]  len_q;
   logic [DATA_W-1:0] seed_q;
   logic              rd_pend_q;   // a read beat happened last cycle
   logic [DATA_W-1:0] rd_data_w;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // ---------------- next state / control ----------------
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_nxt = state;
      accept    = 1'b0;
      beat      = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               accept    = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = REQ;
            end
         end
         // A grant already high on entry still costs one REQ cycle (arbiter park).
         REQ: begin
            if (bus.M_grant)
               state_nxt = XFER;
         end
         XFER: begin
            if (bus.M_grant) begin
               beat = 1'b1;
               if (last)
                  state_nxt = DONE;
               else
                  cnt_inc = 1'b1;
            end else begin
               // Lost grant: index is held and the burst resumes after re-grant.
               state_nxt = REQ;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- beat index ----------------
   bm_beat_cnt #(
      .LEN_W (LEN_W)
   ) u_beat_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .len     (len_q),
      .idx     (idx),
      .last    (last)
   );

   // ---------------- command latch and read-return flag ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: the command registers are reset as well, so a reset mid-burst leaves no stale command behind.
      if (!reset_n) begin
         wr_q      <= 1'b0;
         base_q    <= '0;
         len_q     <= '0;
         seed_q    <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         if (accept) begin
            wr_q   <= bus.cmd_wr;
            base_q <= bus.cmd_addr;
            len_q  <= bus.cmd_len;
            seed_q <= bus.cmd_wdata;
         end
         rd_pend_q <= beat && !wr_q;
      end
   end

   // Read data arrives on M_din the cycle after the beat and is passed straight
   // through under rd_valid, so the last return lines up with done.
   assign rd_data_w = rd_pend_q ? bus.M_din : '0;

   // ---------------- outputs ----------------
   assign bus.cmd_ready = (state == IDLE);
   assign bus.M_req     = (state == REQ) || (state == XFER);
   assign bus.M_wr      = beat && wr_q;
   assign bus.M_addr    = beat ? (base_q + ADDR_W'(idx)) : '0;
   assign bus.M_dout    = (beat && wr_q) ? (seed_q + DATA_W'(idx)) : '0;
   assign bus.done      = (state == DONE);
   assign bus.rd_valid  = rd_pend_q;
   assign bus.rd_data   = rd_data_w;

`ifdef BUS_MASTER_CSUM_EN
   // The accumulator lags rd_data by one cycle; adding the current (gated)
   // return makes csum complete in the done cycle and stable afterwards.
   logic [DATA_W-1:0] csum_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         csum_q <= '0;
      else if (accept)
         csum_q <= '0;
      else if (rd_pend_q)
         csum_q <= csum_q + rd_data_w;
   end

   assign csum = csum_q + rd_data_w;
`endif

endmodule

// File: tb/tb_bus_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_master_ctrl
// Directed testbench for bus_master_ctrl: write burst, single read, withheld
// grant, address wrap, lost grant mid-burst, reset mid-burst then a 3-beat read
// (csum checked when BUS_MASTER_CSUM_EN is defined).
// -----------------------------------------------------------------------------
module tb_bus_master_ctrl;
   import bus_pkg::*;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   nbeat;

   // expected values for the lost-grant burst, cycles N+1..N+8
   logic [7:0]  l_wr   = 8'b0110_0110;
   logic [7:0]  l_addr [8] = '{8'h00, 8'h40, 8'h41, 8'h00, 8'h00, 8'h42, 8'h43, 8'h00};
   logic [31:0] l_dout [8] = '{32'h0, 32'h100, 32'h101, 32'h0, 32'h0, 32'h102, 32'h103, 32'h0};
   // expected addresses for the wrapping burst
   logic [7:0]  wa [3] = '{8'hFE, 8'hFF, 8'h00};

   bus_master_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

`ifdef BUS_MASTER_CSUM_EN
   logic [DATA_W-1:0] csum;
`endif

   bus_master_ctrl #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
`ifdef BUS_MASTER_CSUM_EN
      .csum    (csum),
`endif
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic bus_chk(input string tag, input logic req, input logic wr,
                          input logic [7:0] addr, input logic [31:0] dout, input logic dn);
      check({tag, ".req"},  64'(bus.M_req),  64'(req));
      check({tag, ".wr"},   64'(bus.M_wr),   64'(wr));
      check({tag, ".addr"}, 64'(bus.M_addr), 64'(addr));
      check({tag, ".dout"}, 64'(bus.M_dout), 64'(dout));
      check({tag, ".done"}, 64'(bus.done),   64'(dn));
   endtask

   // Drives a command for one cycle (the accept cycle), then leaves garbage on
   // the command fields; returns at the start of cycle N+1.
   task automatic issue(input string tag, input logic wr, input logic [7:0] addr,
                        input logic [3:0] len, input logic [31:0] seed);
      bus.cmd_valid = 1'b1;
      bus.cmd_wr    = wr;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      bus.cmd_wdata = seed;
      smp();
      check({tag, ".rdy"}, 64'(bus.cmd_ready), 64'd1);
      nxt();
      bus.cmd_valid = 1'b0;
      bus.cmd_wr    = ~wr;
      bus.cmd_addr  = 8'hEE;
      bus.cmd_len   = 4'hF;
      bus.cmd_wdata = 32'hDEAD_BEEF;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_wr    = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.cmd_wdata = '0;
      bus.M_grant   = 1'b0;
      bus.M_din     = '0;

      // ---- reset state ----
      smp();
      bus_chk("rst", 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
      check("rst.rdy", 64'(bus.cmd_ready), 64'd1);
      check("rst.rdv", 64'(bus.rd_valid), 64'd0);
      check("rst.rdd", 64'(bus.rd_data), 64'd0);

      // ---- write burst, grant held; first command right after reset ----
      nxt();
      reset_n     = 1'b1;
      bus.M_grant = 1'b1;
      issue("w1", 1'b1, 8'h10, 4'd3, 32'hA0);
      smp();
      bus_chk("w1.n1", 1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
      check("w1.busy", 64'(bus.cmd_ready), 64'd0);
      for (int i = 0; i < 4; i++) begin
         nxt(); smp();
         bus_chk($sformatf("w1.b%0d", i), 1'b1, 1'b1, 8'(8'h10 + i), 32'(32'hA0 + i), 1'b0);
      end
      nxt(); smp();
      bus_chk("w1.dn", 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
      nxt(); smp();
      check("w1.idle", 64'(bus.cmd_ready), 64'd1);
      check("w1.pulse", 64'(bus.done), 64'd0);

      // ---- single-beat read ----
      nxt();
      bus.M_din = 32'h55;
      issue("r1", 1'b0, 8'h20, 4'd0, 32'h99);
      smp();
      bus_chk("r1.n1", 1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
      nxt(); smp();
      bus_chk("r1.b0", 1'b1, 1'b0, 8'h20, 32'h0, 1'b0);
      check("r1.b0.rdv", 64'(bus.rd_valid), 64'd0);
      nxt(); smp();
      bus_chk("r1.dn", 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
      check("r1.dn.rdv", 64'(bus.rd_valid), 64'd1);
      check("r1.dn.rdd", 64'(bus.rd_data), 64'h55);
`ifdef BUS_MASTER_CSUM_EN
      check("r1.csum", 64'(csum), 64'h55);
`endif
      nxt(); smp();
      check("r1.idle.rdv", 64'(bus.rd_valid), 64'd0);
      check("r1.idle.rdd", 64'(bus.rd_data), 64'd0);
      check("r1.idle.rdy", 64'(bus.cmd_ready), 64'd1);
`ifdef BUS_MASTER_CSUM_EN
      check("r1.csum.hold", 64'(csum), 64'h55);
`endif

      // ---- grant withheld for 5 cycles ----
      nxt();
      bus.M_grant = 1'b0;
      bus.M_din   = '0;
      issue("g", 1'b1, 8'h30, 4'd0, 32'h7);
      for (int k = 1; k <= 5; k++) begin
         smp();
         bus_chk($sformatf("g.w%0d", k), 1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
`ifdef BUS_MASTER_CSUM_EN
         if (k == 1) check("g.csum.clr", 64'(csum), 64'd0);
`endif
         nxt();
      end
      bus.M_grant = 1'b1;
      smp();
      bus_chk("g.seen", 1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
      nxt(); smp();
      bus_chk("g.b0", 1'b1, 1'b1, 8'h30, 32'h7, 1'b0);
      nxt(); smp();
      bus_chk("g.dn", 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);

      // ---- address wrap; cmd_valid held high while busy must be ignored ----
      nxt();
      issue("wrap", 1'b1, 8'hFE, 4'd2, 32'h0);
      bus.cmd_valid = 1'b1;
      smp();
      bus_chk("wrap.n1", 1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         nxt(); smp();
         bus_chk($sformatf("wrap.b%0d", i), 1'b1, 1'b1, wa[i], 32'(i), 1'b0);
      end
      nxt();
      bus.cmd_valid = 1'b0;
      smp();
      bus_chk("wrap.dn", 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
      nxt(); smp();
      check("wrap.noacc.req", 64'(bus.M_req), 64'd0);
      check("wrap.noacc.rdy", 64'(bus.cmd_ready), 64'd1);

      // ---- grant lost after beat 1, then restored ----
      nxt();
      issue("lg", 1'b1, 8'h40, 4'd3, 32'h100);
      nbeat = 0;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) nxt();
         bus.M_grant = (k != 4);
         smp();
         bus_chk($sformatf("lg.c%0d", k), (k != 8), l_wr[k-1], l_addr[k-1], l_dout[k-1], (k == 8));
         if (bus.M_wr) nbeat++;
      end
      check("lg.beats", 64'(nbeat), 64'd4);

      // ---- reset during beat 2 of a read burst ----
      nxt();
      issue("mr", 1'b0, 8'h50, 4'd3, 32'h0);
      nxt(); nxt(); nxt();
      smp();
      check("mr.b2.addr", 64'(bus.M_addr), 64'h52);
      #1 reset_n = 1'b0;
      #1;
      bus_chk("mr.rst", 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
      check("mr.rst.rdy", 64'(bus.cmd_ready), 64'd1);
      check("mr.rst.rdv", 64'(bus.rd_valid), 64'd0);
      nxt();
      reset_n   = 1'b1;
      bus.M_din = '0;

      // ---- new read burst returning 1, 2, 3 ----
      issue("rr", 1'b0, 8'h60, 4'd2, 32'h0);
      smp();
      bus_chk("rr.n1", 1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
      for (int k = 2; k <= 5; k++) begin
         nxt();
         bus.M_din = (k >= 3) ? 32'(k - 2) : 32'h0;
         smp();
         if (k <= 4)
            bus_chk($sformatf("rr.b%0d", k - 2), 1'b1, 1'b0, 8'(8'h60 + k - 2), 32'h0, 1'b0);
         else
            bus_chk("rr.dn", 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
         check($sformatf("rr.c%0d.rdv", k), 64'(bus.rd_valid), (k >= 3) ? 64'd1 : 64'd0);
         check($sformatf("rr.c%0d.rdd", k), 64'(bus.rd_data), (k >= 3) ? 64'(k - 2) : 64'd0);
      end
`ifdef BUS_MASTER_CSUM_EN
      check("rr.csum", 64'(csum), 64'd6);
`endif
      nxt();
      bus.M_din = 32'h99;
      smp();
      check("rr.idle.rdy", 64'(bus.cmd_ready), 64'd1);
      check("rr.idle.rdv", 64'(bus.rd_valid), 64'd0);
`ifdef BUS_MASTER_CSUM_EN
      check("rr.csum.hold", 64'(csum), 64'd6);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
